image_stream_proc: RTL and testbench

- Parametrised successor to the frame reader/processor. Streams one frame from an external pixel memory in display order (top row first, stored bottom-up as in BMP).
- Applies a run-time selectable point operation and emits one RGB pixel per handshake with valid/ready backpressure.
- Sits between the frame buffer and the BMP writer or downstream filters. Replaces internal whole-frame arrays with a 1-cycle-latency memory read port.

---
 rtl/image_stream_proc.sv | 245 ++++++++++++++++++++++++
 tb/tb_image_stream_proc.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_proc.sv
// -----------------------------------------------------------------------------
// image_stream_proc
//   Streams one frame from an external pixel memory in display order (top row
//   first; memory holds rows bottom-up as in BMP). Applies a run-time selectable
//   point operation and emits one RGB pixel per valid/ready handshake.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   start                 frame start request (honoured only when idle)
//   mode/value/threshold  operation select and operands, latched at start
//   mem_rd_en, mem_addr   memory read strobe and pixel word address
//   mem_rdata             {R,G,B}, valid the cycle after mem_rd_en
//   out_valid, out_ready  output handshake
//   DATA_R/G/B            processed pixel
//   sof, eol, eof         first pixel / last of line / last of frame
//   busy                  high when not idle
//   ctrl_done             one-cycle pulse on the final handshake
// -----------------------------------------------------------------------------
module image_stream_proc #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int DW     = 8,
   parameter int AW     = 19
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            start,
   input  logic [2:0]      mode,
   input  logic [DW-1:0]   value,
   input  logic [DW-1:0]   threshold,
   output logic            mem_rd_en,
   output logic [AW-1:0]   mem_addr,
   input  logic [3*DW-1:0] mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   DATA_R,
   output logic [DW-1:0]   DATA_G,
   output logic [DW-1:0]   DATA_B,
   output logic            sof,
   output logic            eol,
   output logic            eof,
   output logic            busy,
   output logic            ctrl_done
);

   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
   // Word address of the first pixel of the top display row (last stored row).
   localparam logic [AW-1:0] BASE_FIRST = AW'(WIDTH * (HEIGHT - 1));
   localparam logic [AW-1:0] LINE_WORDS = AW'(WIDTH);
   localparam logic [DW+1:0] MAX_EXT    = {2'b00, {DW{1'b1}}};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   typedef struct packed {
      logic            sof;
      logic            eol;
      logic            eof;
      logic [3*DW-1:0] rgb;
   } entry_t;

   // Point operation on one {R,G,B} word, computed in DW+2 bits so sums and
   // saturating add/sub never wrap.
   function automatic logic [3*DW-1:0] process_px(input logic [2:0]      op,
                                                   input logic [DW-1:0]   amt,
                                                   input logic [DW-1:0]   thr,
                                                   input logic [3*DW-1:0] px);
      logic [DW+1:0]   ch [3];
      logic [DW+1:0]   sum;
      logic [DW+1:0]   avg;
      logic [DW+1:0]   tmp;
      logic [3*DW-1:0] res;
      ch[0] = {2'b00, px[3*DW-1:2*DW]};
      ch[1] = {2'b00, px[2*DW-1:DW]};
      ch[2] = {2'b00, px[DW-1:0]};
      sum   = ch[0] + ch[1] + ch[2];
      avg   = sum / (DW+2)'(3);
      res   = px;
      for (int k = 0; k < 3; k++) begin
         case (op)
            3'd1: tmp = avg;
            3'd2: begin
               tmp = ch[k] + {2'b00, amt};
               if (tmp > MAX_EXT) tmp = MAX_EXT;
            end
            3'd3: tmp = (ch[k] > {2'b00, amt}) ? ch[k] - {2'b00, amt} : '0;
            3'd4: tmp = (avg > {2'b00, thr}) ? MAX_EXT : '0;
            3'd5: tmp = MAX_EXT - ch[k];
            default: tmp = ch[k];
         endcase
         res[(2-k)*DW +: DW] = tmp[DW-1:0];
      end
      return res;
   endfunction

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [AW-1:0]   base_q, base_d;      // word address of column 0 of the current row
   logic [2:0]      mode_q, mode_d;
   logic [DW-1:0]   value_q, value_d;
   logic [DW-1:0]   thr_q, thr_d;

   // Read issued last cycle; its data is on mem_rdata now.
   logic            infl_q;
   logic [2:0]      infl_flags_q;        // {sof,eol,eof} of the in-flight pixel
   logic [2:0]      rd_flags;

   entry_t          fifo_mem [2];
   logic            wr_ptr_q, rd_ptr_q;
   logic [1:0]      count_q;
   entry_t          entry_in, head;
   logic            push, pop;
   logic [2:0]      occupancy;

   assign push      = infl_q;
   assign head      = fifo_mem[rd_ptr_q];
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign busy      = (state_q != ST_IDLE);
   // Entries committed after this cycle: stored + arriving - leaving.
   assign occupancy = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement leaves it unassigned (which would infer a latch).
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      base_d    = base_q;
      mode_d    = mode_q;
      value_d   = value_q;
      thr_d     = thr_q;
      mem_rd_en = 1'b0;
      ctrl_done = 1'b0;
      rd_flags  = {(row_q == '0) && (col_q == '0),
                   (col_q == COL_LAST),
                   (col_q == COL_LAST) && (row_q == ROW_LAST)};
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               mode_d  = mode;
               value_d = value;
               thr_d   = threshold;
               row_d   = '0;
               col_d   = '0;
               base_d  = BASE_FIRST;
            end
         end
         ST_RUN: begin
            if (occupancy < 3'd2) begin
               mem_rd_en = 1'b1;
               if (col_q == COL_LAST) begin
                  if (row_q == ROW_LAST) begin
                     state_d = ST_DRAIN;
                  end else begin
                     col_d  = '0;
                     row_d  = row_q + 1'b1;
                     base_d = base_q - LINE_WORDS;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // start in this cycle is ignored: the FSM only looks at it in IDLE.
            if (pop && head.eof) begin
               ctrl_done = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_addr = mem_rd_en ? (base_q + AW'(col_q)) : '0;

   always_comb begin
      entry_in.sof = infl_flags_q[2];
      entry_in.eol = infl_flags_q[1];
      entry_in.eof = infl_flags_q[0];
      entry_in.rgb = process_px(mode_q, value_q, thr_q, mem_rdata);
   end

   // Outputs are forced to zero when no pixel is presented.
   always_comb begin
      DATA_R = '0;
      DATA_G = '0;
      DATA_B = '0;
      sof    = 1'b0;
      eol    = 1'b0;
      eof    = 1'b0;
      if (out_valid) begin
         DATA_R = head.rgb[3*DW-1:2*DW];
         DATA_G = head.rgb[2*DW-1:DW];
         DATA_B = head.rgb[DW-1:0];
         sof    = head.sof;
         eol    = head.eol;
         eof    = head.eof;
      end
   end

   always_ff @(posedge HCLK) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge value regardless of block evaluation order.
      if (HRESET) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         base_q       <= '0;
         mode_q       <= '0;
         value_q      <= '0;
         thr_q        <= '0;
         infl_q       <= 1'b0;
         infl_flags_q <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         base_q       <= base_d;
         mode_q       <= mode_d;
         value_q      <= value_d;
         thr_q        <= thr_d;
         infl_q       <= mem_rd_en;
         infl_flags_q <= rd_flags;
         wr_ptr_q     <= wr_ptr_q ^ push;
         rd_ptr_q     <= rd_ptr_q ^ pop;
         count_q      <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: FIFO storage is deliberately not reset; count_q gates every read of
   // it, so stale contents are never visible.
   always_ff @(posedge HCLK) begin
      if (push) fifo_mem[wr_ptr_q] <= entry_in;
   end

endmodule

// File: tb/tb_image_stream_proc.sv
// -----------------------------------------------------------------------------
// tb_image_stream_proc
//   Self-checking bench for image_stream_proc (WIDTH=4, HEIGHT=2). A behavioural
//   memory answers reads one cycle later; expected pixels, addresses and flags
//   come from a display-order frame walk and an integer model of each operation.
// -----------------------------------------------------------------------------
module tb_image_stream_proc;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int DW   = 8;
   localparam int AW   = 19;
   localparam int NPIX = W * H;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          start;
   logic [2:0]    mode;
   logic [DW-1:0] value;
   logic [DW-1:0] threshold;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [23:0]   mem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] DATA_R, DATA_G, DATA_B;
   logic          sof, eol, eof, busy, ctrl_done;

   logic [23:0]   mem [NPIX];
   int            n_checks = 0;
   int            n_fail   = 0;

   image_stream_proc #(.WIDTH(W), .HEIGHT(H), .DW(DW), .AW(AW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
      .threshold(threshold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B), .sof(sof), .eol(eol),
      .eof(eof), .busy(busy), .ctrl_done(ctrl_done)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) begin
      if (mem_rd_en)
         mem_rdata <= (mem_addr < AW'(NPIX)) ? mem[mem_addr[2:0]] : 24'hDEAD00;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [23:0] model(input int m, input int v, input int t,
                                         input logic [23:0] px);
      int c [3];
      int o [3];
      int avg;
      c[0] = int'(px[23:16]);
      c[1] = int'(px[15:8]);
      c[2] = int'(px[7:0]);
      avg  = (c[0] + c[1] + c[2]) / 3;
      for (int k = 0; k < 3; k++) begin
         case (m)
            1: o[k] = avg;
            2: o[k] = (c[k] + v > 255) ? 255 : c[k] + v;
            3: o[k] = (c[k] - v < 0) ? 0 : c[k] - v;
            4: o[k] = (avg > t) ? 255 : 0;
            5: o[k] = 255 - c[k];
            default: o[k] = c[k];
         endcase
      end
      return {8'(o[0]), 8'(o[1]), 8'(o[2])};
   endfunction

   task automatic fill_ramp();
      for (int k = 0; k < NPIX; k++) mem[k] = {8'(k), 8'(k + 8), 8'(k + 16)};
   endtask

   task automatic fill_const(input logic [23:0] px);
      for (int k = 0; k < NPIX; k++) mem[k] = px;
   endtask

   // Runs one frame from idle. Cycle i=0 is the cycle after start is sampled.
   task automatic run_frame(input int m, input int v, input int t, input int ready_pct,
                            input int poke_cycle, input bit start_at_done,
                            output int first_valid, output int done_cycle,
                            output logic [23:0] first_px);
      logic [23:0] exp_px [$];
      logic [2:0]  exp_fl [$];
      int          exp_addr [$];
      int          i, popped, outstanding, ea;
      bit          stalled, pop, exp_done;
      logic [26:0] held, cur;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            exp_addr.push_back(W * (H - 1 - r) + c);
            exp_px.push_back(model(m, v, t, mem[W * (H - 1 - r) + c]));
            exp_fl.push_back({(r == 0 && c == 0), (c == W - 1), (r == H - 1 && c == W - 1)});
         end
      end
      first_valid = -1; done_cycle = -1; first_px = '0;
      i = 0; popped = 0; outstanding = 0; stalled = 0; held = '0;
      mode = 3'(m); value = 8'(v); threshold = 8'(t); start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      while (popped < NPIX && i < 300) begin
         out_ready = ($urandom_range(0, 99) < ready_pct);
         start     = (i == poke_cycle) || (start_at_done && i == NPIX + 1);
         if (i == poke_cycle) mode = 3'd5;
         #1;
         pop = out_valid && out_ready;
         cur = {DATA_R, DATA_G, DATA_B, sof, eol, eof};
         if (mem_rd_en) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
               n_fail++;
               $display("FAIL rd_addr: unexpected read at addr %0d (cycle %0d)", mem_addr, i);
            end else begin
               ea = exp_addr.pop_front();
               if (mem_addr !== AW'(ea)) begin
                  n_fail++;
                  $display("FAIL rd_addr: got %0d expected %0d (cycle %0d)", mem_addr, ea, i);
               end
            end
            n_checks++;
            if (outstanding - int'(pop) >= 2) begin
               n_fail++;
               $display("FAIL issue_rule: read with %0d entries committed (cycle %0d)",
                        outstanding - int'(pop), i);
            end
         end
         if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || cur !== held) begin
               n_fail++;
               $display("FAIL hold: got valid=%b %h expected valid=1 %h", out_valid, cur, held);
            end
         end
         if (out_valid !== 1'b1) begin
            n_checks++;
            if (cur !== '0) begin
               n_fail++;
               $display("FAIL idle_zero: got %h expected 0 (cycle %0d)", cur, i);
            end
         end else if (first_valid < 0) begin
            first_valid = i;
         end
         if (pop) begin
            n_checks++;
            if (cur !== {exp_px[popped], exp_fl[popped]}) begin
               n_fail++;
               $display("FAIL pixel%0d: got %h expected %h", popped, cur,
                        {exp_px[popped], exp_fl[popped]});
            end
            if (popped == 0) first_px = {DATA_R, DATA_G, DATA_B};
         end
         exp_done = pop && exp_fl[popped][0];
         n_checks++;
         if (ctrl_done !== exp_done) begin
            n_fail++;
            $display("FAIL ctrl_done: got %b expected %b (cycle %0d)", ctrl_done, exp_done, i);
         end
         if (ctrl_done === 1'b1) done_cycle = i;
         if (mem_rd_en) outstanding++;
         if (pop) begin
            outstanding--;
            popped++;
         end
         stalled = out_valid && !out_ready;
         held    = cur;
         i++;
         @(negedge HCLK);
      end
      start = 1'b0;
      if (popped < NPIX) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_timeout: got %0d pixels expected %0d", popped, NPIX);
      end
      #1;
      n_checks++;
      if (busy !== 1'b0 || exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL end_idle: got busy=%b missing_reads=%0d expected busy=0 missing_reads=0",
                  busy, exp_addr.size());
      end
   endtask

   task automatic check_all_zero(input string tag);
      n_checks++;
      if ({mem_rd_en, mem_addr, out_valid, DATA_R, DATA_G, DATA_B, sof, eol, eof, busy,
           ctrl_done} !== '0) begin
         n_fail++;
         $display("FAIL %s: got rd=%b addr=%0d valid=%b data=%h flags=%b%b%b busy=%b done=%b expected all 0",
                  tag, mem_rd_en, mem_addr, out_valid, {DATA_R, DATA_G, DATA_B}, sof, eol, eof,
                  busy, ctrl_done);
      end
   endtask

   task automatic test_reset();
      HRESET = 1'b1; start = 1'b0; mode = '0; value = '0; threshold = '0; out_ready = 1'b0;
      repeat (3) @(negedge HCLK);
      #1;
      check_all_zero("reset_state");
      @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
   endtask

   task automatic test_basic();
      int fv, dc;
      logic [23:0] fp;
      fill_ramp();
      run_frame(0, 0, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fv !== 2) begin
         n_fail++;
         $display("FAIL first_valid_latency: got %0d expected 2", fv);
      end
      n_checks++;
      if (dc !== 9) begin
         n_fail++;
         $display("FAIL done_cycle: got %0d expected 9", dc);
      end
      n_checks++;
      if (fp !== 24'h040C14) begin
         n_fail++;
         $display("FAIL basic_first_px: got %h expected 040c14", fp);
      end
   endtask

   task automatic test_ops();
      int fv, dc;
      logic [23:0] fp;
      fill_const({8'd10, 8'd20, 8'd31});
      run_frame(1, 0, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== {3{8'd20}}) begin n_fail++; $display("FAIL gray: got %h expected 141414", fp); end
      run_frame(4, 0, 20, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== 24'h0) begin n_fail++; $display("FAIL thresh20: got %h expected 000000", fp); end
      run_frame(4, 0, 19, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== 24'hFFFFFF) begin n_fail++; $display("FAIL thresh19: got %h expected ffffff", fp); end
      fill_const({8'd200, 8'd155, 8'd0});
      run_frame(2, 100, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== {8'd255, 8'd255, 8'd100}) begin n_fail++; $display("FAIL add: got %h expected ffff64", fp); end
      run_frame(3, 100, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== {8'd100, 8'd55, 8'd0}) begin n_fail++; $display("FAIL sub: got %h expected 643700", fp); end
      run_frame(5, 0, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== {8'd55, 8'd100, 8'd255}) begin n_fail++; $display("FAIL invert: got %h expected 3764ff", fp); end
   endtask

   task automatic test_backpressure();
      int fv, dc;
      logic [23:0] fp;
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < NPIX; k++) mem[k] = 24'($urandom);
         run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), (f == 5) ? 100 : 30, -1, 1'b0, fv, dc, fp);
      end
   endtask

   task automatic test_start_ignored();
      int fv, dc;
      logic [23:0] fp;
      fill_ramp();
      run_frame(0, 0, 0, 100, 3, 1'b0, fv, dc, fp);
      run_frame(2, 37, 0, 50, 5, 1'b0, fv, dc, fp);
   endtask

   task automatic test_back_to_back();
      int fv, dc;
      logic [23:0] fp;
      fill_ramp();
      run_frame(3, 5, 0, 100, -1, 1'b1, fv, dc, fp);
      run_frame(1, 0, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fv !== 2) begin
         n_fail++;
         $display("FAIL restart_latency: got %0d expected 2", fv);
      end
   endtask

   task automatic test_reset_midframe();
      int pops, cyc, fv, dc;
      logic [23:0] fp;
      fill_ramp();
      mode = 3'd0; start = 1'b1; out_ready = 1'b1;
      @(negedge HCLK);
      start = 1'b0; pops = 0; cyc = 0;
      while (pops < 3 && cyc < 50) begin
         #1;
         if (out_valid && out_ready) pops++;
         cyc++;
         @(negedge HCLK);
      end
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      #1;
      check_all_zero("after_reset");
      for (int k = 0; k < 4; k++) begin
         @(negedge HCLK);
         #1;
         n_checks++;
         if (ctrl_done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_frame: got done=%b valid=%b busy=%b expected 0 0 0",
                     ctrl_done, out_valid, busy);
         end
      end
      run_frame(0, 0, 0, 100, -1, 1'b0, fv, dc, fp);
      n_checks++;
      if (fp !== 24'h040C14) begin
         n_fail++;
         $display("FAIL restart_first_px: got %h expected 040c14", fp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ops();
      test_backpressure();
      test_start_ignored();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
